// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS-subset ALU.
//   - opcode constants (instruction bits [31:26])
//   - funct constants  (instruction bits [5:0], meaningful only for R-type)
//   - alu_op_e: the internal operation selected by the decoder
package alu_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_NONE
  } alu_op_e;

endpackage

// File: rtl/alu_control.sv
// ALU decoder: maps (opcode, func_field) to an alu_op_e.
// Purely combinational. Anything not recognised decodes to ALU_NONE,
// which the datapath turns into a zero result.
//   opcode     - instruction bits [31:26]
//   func_field - instruction bits [5:0], used only for R-type
//   alu_op     - selected operation
module alu_control
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func_field,
  output alu_op_e    alu_op
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven,
    // so no latch is inferred for unlisted opcode/funct values.
    alu_op = ALU_NONE;
    case (opcode)
      OP_RTYPE: begin
        case (func_field)
          F_ADD, F_ADDU: alu_op = ALU_ADD;
          F_SUB, F_SUBU: alu_op = ALU_SUB;
          F_AND:         alu_op = ALU_AND;
          F_OR:          alu_op = ALU_OR;
          F_XOR:         alu_op = ALU_XOR;
          F_NOR:         alu_op = ALU_NOR;
          F_SLT:         alu_op = ALU_SLT;
          F_SLTU:        alu_op = ALU_SLTU;
          default:       alu_op = ALU_NONE;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI, OP_ADDIU: alu_op = ALU_ADD;
      // Branches only need the difference; the branch unit reads zero.
      OP_BEQ, OP_BNE:                  alu_op = ALU_SUB;
      OP_ANDI:                         alu_op = ALU_AND;
      OP_ORI:                          alu_op = ALU_OR;
      OP_XORI:                         alu_op = ALU_XOR;
      OP_SLTI:                         alu_op = ALU_SLT;
      OP_SLTIU:                        alu_op = ALU_SLTU;
      default:                         alu_op = ALU_NONE;
    endcase
  end

endmodule

// File: rtl/alu_top.sv
// Registered 32-bit MIPS-subset ALU for the EX stage.
// The decoded operation is applied to A and B combinationally and the
// result plus its zero flag are registered on the rising clock edge,
// giving a fixed one-cycle latency with a new operation every cycle.
//   clk        - system clock
//   rst        - synchronous, active-high reset (result=0, zero=1)
//   opcode     - instruction bits [31:26]
//   func_field - instruction bits [5:0]
//   A, B       - operands (B already muxed/extended by the datapath)
//   result     - registered ALU result
//   zero       - registered flag, set when result is zero
module alu_top
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func_field,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  alu_op_e          alu_op;
  logic [WIDTH-1:0] next_result;

  alu_control u_alu_control (
    .opcode     (opcode),
    .func_field (func_field),
    .alu_op     (alu_op)
  );

  // Arithmetic wraps modulo 2^WIDTH; overflow is deliberately ignored.
  always_comb begin
    next_result = '0;
    case (alu_op)
      ALU_ADD:  next_result = A + B;
      ALU_SUB:  next_result = A - B;
      ALU_AND:  next_result = A & B;
      ALU_OR:   next_result = A | B;
      ALU_XOR:  next_result = A ^ B;
      ALU_NOR:  next_result = ~(A | B);
      ALU_SLT:  next_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: next_result = {{(WIDTH-1){1'b0}}, (A < B)};
      default:  next_result = '0;
    endcase
  end

  // zero is derived from next_result so it always matches the registered result.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples
    // pre-edge values, independent of statement order.
    if (rst) begin
      result <= '0;
      zero   <= 1'b1;
    end else begin
      result <= next_result;
      zero   <= (next_result == '0);
    end
  end

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: directed scenarios plus randomized
// operations compared against a behavioural model of the instruction set.
module tb_alu_top;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  func_field;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] result;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;

  alu_top #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .func_field (func_field),
    .A          (A),
    .B          (B),
    .result     (result),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  // Behavioural model written straight from the instruction semantics.
  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b);
    int signed   sa = a;
    int signed   sb = b;
    longint      sum = longint'(a) + longint'(b);
    logic [31:0] r = 32'd0;
    if (op == 6'h00) begin
      if (fn == 6'h20 || fn == 6'h21) r = sum[31:0];
      else if (fn == 6'h22 || fn == 6'h23) r = a + ~b + 32'd1;
      else if (fn == 6'h24) r = a & b;
      else if (fn == 6'h25) r = a | b;
      else if (fn == 6'h26) r = a ^ b;
      else if (fn == 6'h27) r = ~(a | b);
      else if (fn == 6'h2A) r = (sa < sb) ? 32'd1 : 32'd0;
      else if (fn == 6'h2B) r = (a < b) ? 32'd1 : 32'd0;
    end else begin
      if (op == 6'h23 || op == 6'h2B || op == 6'h08 || op == 6'h09) r = sum[31:0];
      else if (op == 6'h04 || op == 6'h05) r = a + ~b + 32'd1;
      else if (op == 6'h0C) r = a & b;
      else if (op == 6'h0D) r = a | b;
      else if (op == 6'h0E) r = a ^ b;
      else if (op == 6'h0A) r = (sa < sb) ? 32'd1 : 32'd0;
      else if (op == 6'h0B) r = (a < b) ? 32'd1 : 32'd0;
    end
    return r;
  endfunction

  // Drive one operation on the falling edge, then wait past the next rising edge.
  task automatic step(input logic [5:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    opcode = op; func_field = fn; A = a; B = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(6'($urandom), 6'($urandom), $urandom, $urandom);
      n_checks++;
      if (result !== 32'd0 || zero !== 1'b1) begin
        n_fail++;
        $display("FAIL reset[%0d]: result=%h zero=%b, expected result=0 zero=1", i, result, zero);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    step(6'h00, 6'h20, 32'd2, 32'd3);
    n_checks++;
    if (result !== 32'd5 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_add: result=%h zero=%b, expected 5/0", result, zero);
    end
  endtask

  task automatic test_add_and();
    step(6'h00, 6'h20, 32'h2222, 32'h1111);
    n_checks++;
    if (result !== 32'h3333 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL rtype_add: result=%h zero=%b, expected 3333/0", result, zero);
    end
    step(6'h00, 6'h24, 32'h2222, 32'h1111);
    n_checks++;
    if (result !== 32'h0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL rtype_and: result=%h zero=%b, expected 0/1", result, zero);
    end
  endtask

  task automatic test_lw();
    step(6'h23, 6'h00, 32'h2222, 32'h1111);
    n_checks++;
    if (result !== 32'h3333 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL lw: result=%h zero=%b, expected 3333/0", result, zero);
    end
  endtask

  task automatic test_beq();
    step(6'h04, 6'h00, 32'h5555, 32'h5555);
    n_checks++;
    if (result !== 32'h0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL beq_equal: result=%h zero=%b, expected 0/1", result, zero);
    end
    step(6'h04, 6'h00, 32'h5556, 32'h5555);
    n_checks++;
    if (result !== 32'h1 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL beq_diff: result=%h zero=%b, expected 1/0", result, zero);
    end
  endtask

  task automatic test_slt();
    step(6'h00, 6'h2A, 32'h1111, 32'h2222);
    n_checks++;
    if (result !== 32'h1) begin
      n_fail++;
      $display("FAIL slt_pos: result=%h, expected 1", result);
    end
    step(6'h00, 6'h2A, 32'hFFFF_FFFF, 32'h1);
    n_checks++;
    if (result !== 32'h1 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL slt_signed: result=%h zero=%b, expected 1/0", result, zero);
    end
    step(6'h00, 6'h2B, 32'hFFFF_FFFF, 32'h1);
    n_checks++;
    if (result !== 32'h0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL sltu: result=%h zero=%b, expected 0/1", result, zero);
    end
  endtask

  task automatic test_wrap_unsupported();
    step(6'h00, 6'h20, 32'hFFFF_FFFF, 32'h1);
    n_checks++;
    if (result !== 32'h0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL add_wrap: result=%h zero=%b, expected 0/1", result, zero);
    end
    // Load a non-zero value first so a stale register cannot mask the check.
    step(6'h0D, 6'h00, 32'hA5A5_0000, 32'h0000_5A5A);
    n_checks++;
    if (result !== 32'hA5A5_5A5A) begin
      n_fail++;
      $display("FAIL ori: result=%h, expected a5a55a5a", result);
    end
    step(6'h3F, 6'h20, 32'h1234, 32'h5678);
    n_checks++;
    if (result !== 32'h0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_opcode: result=%h zero=%b, expected 0/1", result, zero);
    end
    step(6'h0D, 6'h00, 32'h1, 32'h2);
    step(6'h00, 6'h3F, 32'h1234, 32'h5678);
    n_checks++;
    if (result !== 32'h0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_funct: result=%h zero=%b, expected 0/1", result, zero);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops [6] = '{6'h00, 6'h00, 6'h00, 6'h0E, 6'h0A, 6'h05};
    logic [5:0]  fns [6] = '{6'h22, 6'h27, 6'h26, 6'h00, 6'h00, 6'h00};
    logic [31:0] exp_r;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      exp_r = ref_alu(ops[i], fns[i], a, b);
      step(ops[i], fns[i], a, b);
      n_checks++;
      if (result !== exp_r || zero !== (exp_r == 32'd0)) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] op=%h fn=%h: result=%h zero=%b, expected %h", i,
                 ops[i], fns[i], result, zero, exp_r);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0]  op_pool [13] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h09, 6'h04, 6'h05,
                                  6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h00};
    logic [5:0]  fn_pool [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                  6'h27, 6'h2A, 6'h2B};
    logic [5:0]  op, fn;
    logic [31:0] a, b, exp_r;
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 12)];
      fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 9)];
      a  = $urandom;
      // Bias towards equal/near operands to exercise zero and compares.
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a + 32'($urandom_range(0, 2)) - 32'd1;
        default: b = $urandom;
      endcase
      exp_r = ref_alu(op, fn, a, b);
      step(op, fn, a, b);
      n_checks++;
      if (result !== exp_r || zero !== (exp_r == 32'd0)) begin
        n_fail++;
        $display("FAIL random[%0d] op=%h fn=%h a=%h b=%h: result=%h zero=%b, expected %h",
                 i, op, fn, a, b, result, zero, exp_r);
      end
    end
  endtask

  initial begin
    rst = 1'b1; opcode = '0; func_field = '0; A = '0; B = '0;
    test_reset();
    test_add_and();
    test_lw();
    test_beq();
    test_slt();
    test_wrap_unsupported();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
